// File: rtl/id_scan_display_if.sv
// Bus between the id source / display consumer and id_scan_display.
// With ID_FREEZE_EN defined the bus also carries the freeze request.
interface id_scan_display_if;
  logic [3:0]  id;
`ifdef ID_FREEZE_EN
  logic        freeze;
`endif
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [31:0] hist;
  logic        sample_tick;

`ifdef ID_FREEZE_EN
  modport master (output id, output freeze, input seg, input an, input hist, input sample_tick);
  modport slave  (input id, input freeze, output seg, output an, output hist, output sample_tick);
`else
  modport master (output id, input seg, input an, input hist, input sample_tick);
  modport slave  (input id, output seg, output an, output hist, output sample_tick);
`endif
endinterface

// File: rtl/id_scan_display.sv
// Periodically captures an id digit stream into an 8-digit history and scans it
// onto a multiplexed active-low 7-segment display. Optional macro: ID_FREEZE_EN.
module id_scan_display #(
  parameter int SAMPLE_DIV = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  id_scan_display_if.slave bus
);

  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] SCAN_LAST   = 8'(SCAN_DIV - 1);

  logic [7:0]  r_sample_cnt;
  logic [7:0]  r_scan_cnt;
  logic [2:0]  r_digit;
  logic [31:0] r_hist;
  logic        r_tick;
  logic [6:0]  r_seg;
  logic [7:0]  r_an;

  logic [3:0]  w_nib [8];
  logic        w_capture;
  logic        w_hold;
  logic        w_scan_wrap;
  logic [6:0]  w_seg_dec;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign w_nib[gi] = r_hist[4*gi +: 4];
    end
  endgenerate

  assign w_capture   = (r_sample_cnt == SAMPLE_LAST);
  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);

`ifdef ID_FREEZE_EN
  assign w_hold = bus.freeze;
`else
  assign w_hold = 1'b0;
`endif

  // Decode uses the pre-edge history, so a simultaneous capture shows next update
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib[r_digit])
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sample_cnt <= 8'd0;
      r_scan_cnt   <= 8'd0;
      r_digit      <= 3'd0;
      r_hist       <= 32'd0;
      r_tick       <= 1'b0;
      r_seg        <= 7'h7F;
      r_an         <= 8'hFF;
    end else begin
      r_sample_cnt <= w_capture ? 8'd0 : r_sample_cnt + 8'd1;
      if (w_capture && !w_hold) begin
        r_hist <= {r_hist[27:0], bus.id};
      end
      r_tick <= w_capture && !w_hold;

      if (w_scan_wrap) begin
        r_scan_cnt <= 8'd0;
        r_digit    <= r_digit + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 8'd1;
      end

      r_an  <= ~(8'b1 << r_digit);
      r_seg <= w_seg_dec;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.an          = r_an;
  assign bus.hist        = r_hist;
  assign bus.sample_tick = r_tick;

endmodule

// File: tb/tb_id_scan_display.sv
// Bench for id_scan_display: two instances (SAMPLE_DIV 4 / SCAN_DIV 2 and
// SAMPLE_DIV 1 / SCAN_DIV 9) compared against a queue-based model of the display.
module tb_id_scan_display;

  localparam int SA = 4;
  localparam int CA = 2;
  localparam int SB = 1;
  localparam int CB = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_scan_display_if bus_a ();
  id_scan_display_if bus_b ();

  id_scan_display #(.SAMPLE_DIV(SA), .SCAN_DIV(CA)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  id_scan_display #(.SAMPLE_DIV(SB), .SCAN_DIV(CB)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  // Model: k counts released edges; queues hold captured digits, oldest first
  int         k;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [31:0] ea_hist, eb_hist;
  logic [6:0]  ea_seg, eb_seg;
  logic [7:0]  ea_an, eb_an;
  logic        ea_tick, eb_tick;
`ifdef ID_FREEZE_EN
  logic        freeze_drv = 1'b0;
`endif

  task automatic cycle(input logic [3:0] v, input logic rn);
    int   da, db;
    logic frz;
    logic [3:0] na, nb;
    frz = 1'b0;
`ifdef ID_FREEZE_EN
    frz = freeze_drv;
    bus_a.freeze = freeze_drv;
    bus_b.freeze = freeze_drv;
`endif
    bus_a.id = v;
    bus_b.id = v;
    reset = rn;
    if (!rn) begin
      k = 0;
      qa.delete();
      qb.delete();
      ea_seg = 7'h7F; eb_seg = 7'h7F;
      ea_an = 8'hFF;  eb_an = 8'hFF;
      ea_tick = 1'b0; eb_tick = 1'b0;
    end else begin
      k++;
      da = ((k - 1) / CA) % 8;
      db = ((k - 1) / CB) % 8;
      na = (da < qa.size()) ? qa[qa.size() - 1 - da] : 4'h0;
      nb = (db < qb.size()) ? qb[qb.size() - 1 - db] : 4'h0;
      ea_an = an_seq[da];
      eb_an = an_seq[db];
      ea_seg = seg_tab[na];
      eb_seg = seg_tab[nb];
      ea_tick = ((k % SA) == 0) && !frz;
      eb_tick = ((k % SB) == 0) && !frz;
      if (ea_tick) begin
        qa.push_back(v);
        if (qa.size() > 8) void'(qa.pop_front());
      end
      if (eb_tick) begin
        qb.push_back(v);
        if (qb.size() > 8) void'(qb.pop_front());
      end
    end
    ea_hist = 32'd0;
    eb_hist = 32'd0;
    for (int d = 0; d < qa.size(); d++) ea_hist[4*d +: 4] = qa[qa.size() - 1 - d];
    for (int d = 0; d < qb.size(); d++) eb_hist[4*d +: 4] = qb[qb.size() - 1 - d];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'($urandom), 1'b0);
      n_vec++;
      if (bus_a.seg !== 7'h7F || bus_a.an !== 8'hFF) begin
        n_err++;
        $display("FAIL reset_hold: seg=%h an=%h required seg=7f an=ff", bus_a.seg, bus_a.an);
      end
      n_vec++;
      if (bus_a.hist !== 32'd0 || bus_a.sample_tick !== 1'b0 || bus_b.hist !== 32'd0) begin
        n_err++;
        $display("FAIL reset_state: hist_a=%h tick=%b hist_b=%h required 0", bus_a.hist, bus_a.sample_tick, bus_b.hist);
      end
    end
    cycle(4'h5, 1'b1);
    n_vec++;
    if (bus_a.an !== 8'hFE || bus_a.seg !== 7'h40) begin
      n_err++;
      $display("FAIL reset_release: an=%h seg=%h required an=fe seg=40", bus_a.an, bus_a.seg);
    end
    $display("test_reset done: first released edge an=%h seg=%h", bus_a.an, bus_a.seg);
  endtask

  task automatic test_sample_div1();
    logic [31:0] ids;
    ids = 32'h0931F2E1;
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(ids[31 - 4*i -: 4], 1'b1);
      n_vec++;
      if (bus_b.hist !== eb_hist || bus_b.sample_tick !== 1'b1) begin
        n_err++;
        $display("FAIL div1_capture[%0d]: hist=%h tick=%b required hist=%h tick=1", i, bus_b.hist, bus_b.sample_tick, eb_hist);
      end
    end
    n_vec++;
    if (bus_b.hist !== 32'h0931F2E1) begin
      n_err++;
      $display("FAIL div1_hist: hist=%h required 0931f2e1", bus_b.hist);
    end
    cycle(4'h7, 1'b1);
    n_vec++;
    if (bus_b.seg !== 7'h79 || bus_b.an !== 8'hFE) begin
      n_err++;
      $display("FAIL div1_display: seg=%h an=%h required seg=79 an=fe", bus_b.seg, bus_b.an);
    end
    $display("test_sample_div1 done: hist=%h seg=%h an=%h", bus_b.hist, bus_b.seg, bus_b.an);
  endtask

  task automatic test_sample_div4();
    int ticks;
    ticks = 0;
    cycle(4'h9, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      cycle(4'h9, 1'b1);
      if (bus_a.sample_tick === 1'b1) ticks++;
      n_vec++;
      if (bus_a.sample_tick !== ((i % 4) == 0)) begin
        n_err++;
        $display("FAIL div4_tick[%0d]: tick=%b required %b", i, bus_a.sample_tick, (i % 4) == 0);
      end
    end
    n_vec++;
    if (ticks != 8 || bus_a.hist !== 32'h99999999) begin
      n_err++;
      $display("FAIL div4_hist: pulses=%0d hist=%h required 8 pulses hist=99999999", ticks, bus_a.hist);
    end
    $display("test_sample_div4 done: pulses=%0d hist=%h", ticks, bus_a.hist);
  endtask

  task automatic test_scan();
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(4'($urandom), 1'b1);
      n_vec++;
      if (bus_a.an !== an_seq[(i / 2) % 8]) begin
        n_err++;
        $display("FAIL scan_an[%0d]: an=%h required %h", i, bus_a.an, an_seq[(i / 2) % 8]);
      end
    end
    $display("test_scan done: an=%h after 20 released edges", bus_a.an);
  endtask

  task automatic test_reset_on_capture();
    logic [31:0] ids;
    ids = 32'h0931F2E1;
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 32; i++) cycle(ids[31 - 4*(i / 4) -: 4], 1'b1);
    n_vec++;
    if (bus_a.hist !== 32'h0931F2E1) begin
      n_err++;
      $display("FAIL rst_cap_setup: hist=%h required 0931f2e1", bus_a.hist);
    end
    for (int i = 0; i < 3; i++) cycle(4'hA, 1'b1);
    cycle(4'hA, 1'b0);
    n_vec++;
    if (bus_a.hist !== 32'd0 || bus_a.sample_tick !== 1'b0 || bus_a.an !== 8'hFF || bus_a.seg !== 7'h7F) begin
      n_err++;
      $display("FAIL rst_cap: hist=%h tick=%b an=%h seg=%h required 0/0/ff/7f",
               bus_a.hist, bus_a.sample_tick, bus_a.an, bus_a.seg);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(4'h3, 1'b1);
      n_vec++;
      if (bus_a.sample_tick !== (i == 4)) begin
        n_err++;
        $display("FAIL rst_cap_restart[%0d]: tick=%b required %b", i, bus_a.sample_tick, i == 4);
      end
    end
    n_vec++;
    if (bus_a.hist !== 32'h00000003) begin
      n_err++;
      $display("FAIL rst_cap_first: hist=%h required 00000003", bus_a.hist);
    end
    $display("test_reset_on_capture done: hist=%h", bus_a.hist);
  endtask

`ifdef ID_FREEZE_EN
  task automatic test_freeze();
    logic [31:0] held;
    freeze_drv = 1'b0;
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(4'(i + 4), 1'b1);
    held = bus_a.hist;
    freeze_drv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(4'hC, 1'b1);
      n_vec++;
      if (bus_a.hist !== held || bus_a.sample_tick !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_hold[%0d]: hist=%h tick=%b required hist=%h tick=0", i, bus_a.hist, bus_a.sample_tick, held);
      end
    end
    freeze_drv = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle(4'hD, 1'b1);
      n_vec++;
      if (bus_a.sample_tick !== (i == 4)) begin
        n_err++;
        $display("FAIL freeze_resume[%0d]: tick=%b required %b", i, bus_a.sample_tick, i == 4);
      end
    end
    n_vec++;
    if (bus_a.hist !== {held[27:0], 4'hD}) begin
      n_err++;
      $display("FAIL freeze_capture: hist=%h required %h", bus_a.hist, {held[27:0], 4'hD});
    end
    $display("test_freeze done: hist=%h", bus_a.hist);
  endtask
`endif

  task automatic test_random();
    logic rn;
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 39) != 0);
`ifdef ID_FREEZE_EN
      freeze_drv = ($urandom_range(0, 3) == 0);
`endif
      cycle(4'($urandom), rn);
      n_vec++;
      if (bus_a.hist !== ea_hist || bus_a.seg !== ea_seg || bus_a.an !== ea_an || bus_a.sample_tick !== ea_tick) begin
        n_err++;
        $display("FAIL rand_a[%0d]: hist=%h seg=%h an=%h tick=%b required %h %h %h %b",
                 i, bus_a.hist, bus_a.seg, bus_a.an, bus_a.sample_tick, ea_hist, ea_seg, ea_an, ea_tick);
      end
      n_vec++;
      if (bus_b.hist !== eb_hist || bus_b.seg !== eb_seg || bus_b.an !== eb_an || bus_b.sample_tick !== eb_tick) begin
        n_err++;
        $display("FAIL rand_b[%0d]: hist=%h seg=%h an=%h tick=%b required %h %h %h %b",
                 i, bus_b.hist, bus_b.seg, bus_b.an, bus_b.sample_tick, eb_hist, eb_seg, eb_an, eb_tick);
      end
      n_vec++;
      if ($countones(~bus_a.an) > 1 || $countones(~bus_b.an) > 1) begin
        n_err++;
        $display("FAIL rand_onehot[%0d]: an_a=%h an_b=%h required at most one low bit", i, bus_a.an, bus_b.an);
      end
    end
`ifdef ID_FREEZE_EN
    freeze_drv = 1'b0;
`endif
    $display("test_random done: 400 cycles, last hist_a=%h hist_b=%h", bus_a.hist, bus_b.hist);
  endtask

  initial begin
    bus_a.id = 4'h0;
    bus_b.id = 4'h0;
`ifdef ID_FREEZE_EN
    bus_a.freeze = 1'b0;
    bus_b.freeze = 1'b0;
`endif
    test_reset();
    test_sample_div1();
    test_sample_div4();
    test_scan();
    test_reset_on_capture();
`ifdef ID_FREEZE_EN
    test_freeze();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
